reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 158 +++++++++++++++
 tb/tb_reg_dump_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader
// Purpose  : Walks a range of a register file through its asynchronous read
//            port and presents each word on a valid/ready stream. The walk
//            wraps modulo 2**ADDR_WIDTH when last_addr < first_addr.
//            Compile-time option REG_DUMP_CHECKSUM_EN adds a running XOR
//            checksum of the accepted words.
// Ports    : clk         - sole clock, rising edge
//            reset       - synchronous active-high reset
//            start       - dump request, sampled only while idle
//            first_addr  - first register of the range (sampled with start)
//            last_addr   - last register of the range (sampled with start)
//            rf_addr     - register-file read address (always equals idx)
//            rf_data     - register-file read data for rf_addr, same cycle
//            dump_valid  - dump_addr/dump_data hold a word for the consumer
//            dump_ready  - consumer accepts the presented word
//            dump_addr   - address of the presented word
//            dump_data   - captured register value
//            busy        - high whenever a dump is in progress
//            done        - one-cycle pulse when a dump completes
//            checksum    - (REG_DUMP_CHECKSUM_EN only) XOR of accepted words
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [REG_WIDTH-1:0]  rf_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [REG_WIDTH-1:0]  dump_data,
  output logic                  busy,
`ifdef REG_DUMP_CHECKSUM_EN
  output logic [REG_WIDTH-1:0]  checksum,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ZERO = '0;
  localparam logic [REG_WIDTH-1:0]  C_DATA_ZERO = '0;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   end_idx_q, end_idx_d;
  logic [ADDR_WIDTH-1:0]   dump_addr_q, dump_addr_d;
  logic [REG_WIDTH-1:0]    dump_data_q, dump_data_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_WIDTH-1:0]    checksum_q, checksum_d;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    end_idx_d   = end_idx_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
`ifdef REG_DUMP_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif

    case (state_q)
      S_IDLE: begin
        // The range is only latched here, so start while busy cannot
        // disturb idx or end_idx.
        if (start) begin
          idx_d     = first_addr;
          end_idx_d = last_addr;
`ifdef REG_DUMP_CHECKSUM_EN
          checksum_d = C_DATA_ZERO;
`endif
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        // rf_addr already equals idx, so rf_data is the word to capture.
        dump_addr_d = idx_q;
        dump_data_d = rf_data;
        state_d     = S_SEND;
      end

      S_SEND: begin
        if (dump_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
          checksum_d = checksum_q ^ dump_data_q;
`endif
          if (idx_q == end_idx_q) begin
            state_d = S_DONE;
          end else begin
            // Natural overflow of the ADDR_WIDTH-bit add gives the wrap.
            idx_d   = idx_q + C_IDX_ONE;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= C_ADDR_ZERO;
      end_idx_q   <= C_ADDR_ZERO;
      dump_addr_q <= C_ADDR_ZERO;
      dump_data_q <= C_DATA_ZERO;
`ifdef REG_DUMP_CHECKSUM_EN
      checksum_q  <= C_DATA_ZERO;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      end_idx_q   <= end_idx_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
`ifdef REG_DUMP_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // Outputs are decoded from registered state only.
  assign rf_addr    = idx_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_valid = (state_q == S_SEND);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
`ifdef REG_DUMP_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_reader
// Purpose  : Directed self-checking bench for reg_dump_reader. A behavioural
//            register file answers rf_addr combinationally; register k holds
//            k*4 except where a step overrides it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

  localparam int AW = 5;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rf_addr;
  logic [RW-1:0] rf_data;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [RW-1:0] dump_data;
  logic          busy;
  logic          done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [RW-1:0] checksum;
`endif

  logic [RW-1:0] rf_mem [0:31];
  assign rf_data = rf_mem[rf_addr];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_dump_reader #(
    .ADDR_WIDTH (AW),
    .REG_WIDTH  (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .busy       (busy),
`ifdef REG_DUMP_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one dump with dump_ready tied high, starting from an idle negedge.
  // c counts negedges from the FETCH of the first word: word k is presented
  // at c=2k+1, done at c=2n, idle again at c=2n+1.
  task automatic run_dump(input int first, input int last, input int nwords, input string tag);
    int k;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int last_acc;
    int exp_a;
    k = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; last_acc = -10;
    start      = 1'b1;
    first_addr = AW'(first);
    last_addr  = AW'(last);
    dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (dump_valid && dump_ready) begin
        exp_a = (first + k) % 32;
        check({tag, "_addr"}, 64'(dump_addr), 64'(exp_a));
        check({tag, "_data"}, 64'(dump_data), 64'(exp_a * 4));
        check({tag, "_rfaddr"}, 64'(rf_addr), 64'(exp_a));
        check({tag, "_slot"}, 64'(c), 64'(2 * k + 1));
        last_acc = c;
        k++;
      end
      if (!busy && c > 0) break;
      @(negedge clk);
    end
    check({tag, "_words"}, 64'(k), 64'(nwords));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(2 * nwords + 1));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_after_last"}, 64'(done_at), 64'(last_acc + 1));
    check({tag, "_idle_at_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  found;
    int  k;
    int  seen_done;
    int  seen_valid;
    int  exp_list [2];

    for (int i = 0; i < 32; i++) rf_mem[i] = RW'(i * 4);
    reset      = 1'b1;
    start      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    dump_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(dump_valid), 64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_done",  64'(done),       64'd0);
    check("rst_addr",  64'(dump_addr),  64'd0);
    check("rst_data",  64'(dump_data),  64'd0);
    check("rst_rfaddr", 64'(rf_addr),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full range, single word, wrapping range
    run_dump(0, 31, 32, "full");
    @(negedge clk);
    run_dump(3, 3, 1, "single");
    @(negedge clk);
    run_dump(30, 1, 4, "wrap");
    @(negedge clk);

    // Backpressure at address 7 with a start pulse that must be ignored
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd9; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (dump_valid && dump_addr == 5'd7) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("stall_reach7", 64'(found), 64'd1);
    dump_ready = 1'b0;
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      start = 1'b0;
      check("stall_valid", 64'(dump_valid), 64'd1);
      check("stall_addr",  64'(dump_addr),  64'd7);
      check("stall_data",  64'(dump_data),  64'd28);
    end
    dump_ready = 1'b1;
    @(negedge clk);
    exp_list[0] = 8; exp_list[1] = 9;
    k = 0; seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) seen_done++;
      if (dump_valid && dump_ready) begin
        if (k < 2) check("stall_tail_addr", 64'(dump_addr), 64'(exp_list[k]));
        k++;
      end
      if (!busy) break;
      @(negedge clk);
    end
    check("stall_tail_words", 64'(k), 64'd2);
    check("stall_tail_done",  64'(seen_done), 64'd1);
    check("stall_idle", 64'(busy), 64'd0);
    @(negedge clk);

    // Reset in SEND at address 10 aborts the dump
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 60; c++) begin
      if (dump_valid && dump_addr == 5'd10) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach10", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid",  64'(dump_valid), 64'd0);
    check("abort_busy",   64'(busy),       64'd0);
    check("abort_done",   64'(done),       64'd0);
    check("abort_addr",   64'(dump_addr),  64'd0);
    check("abort_data",   64'(dump_data),  64'd0);
    check("abort_rfaddr", 64'(rf_addr),    64'd0);
    seen_done = 0; seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (dump_valid) seen_valid++;
    end
    check("abort_no_done",  64'(seen_done),  64'd0);
    check("abort_no_valid", 64'(seen_valid), 64'd0);

    // Normal operation resumes after the abort
    run_dump(12, 13, 2, "post_abort");
    @(negedge clk);

`ifdef REG_DUMP_CHECKSUM_EN
    rf_mem[1] = 32'h0000_000F;
    rf_mem[2] = 32'h0000_00F0;
    rf_mem[3] = 32'h0000_00FF;
    start = 1'b1; first_addr = 5'd1; last_addr = 5'd3; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("csum3_done", 64'(found), 64'd1);
    check("csum3_value", 64'(checksum), 64'h0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; first_addr = 5'd1; last_addr = 5'd2;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("csum2_done", 64'(found), 64'd1);
    check("csum2_value", 64'(checksum), 64'hFF);
    @(negedge clk);
    for (int i = 1; i < 4; i++) rf_mem[i] = RW'(i * 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
